// File: rtl/echo_delay.sv
// Stereo feedback-delay stage: mixes each input frame with an attenuated copy of the
// output from `delay` frames earlier, held in a circular single-port buffer.
module echo_delay #(
   parameter int DEPTH_LOG2 = 12,
   parameter int DATA_W     = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_valid,
   input  logic signed [DATA_W-1:0] i_left_in,
   input  logic signed [DATA_W-1:0] i_right_in,
   input  logic [DEPTH_LOG2-1:0]    i_delay,
   input  logic [7:0]               i_gain,
   input  logic                     i_bypass,
   output logic signed [DATA_W-1:0] o_left_out,
   output logic signed [DATA_W-1:0] o_right_out,
   output logic                     o_out_valid,
   output logic                     o_busy,
   output logic                     o_overrun
);

   localparam int Depth = 2 ** DEPTH_LOG2;
   localparam int SumW  = DATA_W + 2;
   localparam int ProdW = DATA_W + 9;
   localparam int WordW = 2 * DATA_W;

   typedef enum logic [1:0] {StIdle, StRead, StWait, StMix} state_t;

   state_t r_state;
   state_t w_state_next;

   logic signed [DATA_W-1:0] r_x_l, r_x_r;
   logic signed [DATA_W-1:0] r_d_l, r_d_r;
   logic [DEPTH_LOG2-1:0]    r_delay;
   logic [7:0]               r_gain;
   logic                     r_bypass;
   logic                     r_d_zero;
   logic [DEPTH_LOG2-1:0]    r_wr_ptr;
   logic [DEPTH_LOG2-1:0]    r_fill;

   logic [WordW-1:0]         r_mem [Depth];
   logic [WordW-1:0]         r_ram_rdata;

   logic                     w_accept;
   logic [DEPTH_LOG2-1:0]    w_rd_addr;
   logic [DEPTH_LOG2-1:0]    w_ram_addr;
   logic                     w_ram_we;
   logic [WordW-1:0]         w_ram_wdata;
   logic                     w_d_zero;
   logic signed [ProdW-1:0]  w_p_l, w_p_r;
   logic signed [SumW-1:0]   w_e_l, w_e_r;
   logic signed [SumW-1:0]   w_s_l, w_s_r;
   logic signed [DATA_W-1:0] w_y_l, w_y_r;
   logic                     w_unused;

   function automatic logic signed [DATA_W-1:0] sat(input logic signed [SumW-1:0] s);
      logic signed [DATA_W-1:0] res;
      // In range when the two guard bits agree with the result sign bit.
      if (s[SumW-1:DATA_W-1] == '0 || s[SumW-1:DATA_W-1] == '1) begin
         res = s[DATA_W-1:0];
      end else if (s[SumW-1]) begin
         res = {1'b1, {(DATA_W-1){1'b0}}};
      end else begin
         res = {1'b0, {(DATA_W-1){1'b1}}};
      end
      return res;
   endfunction

   // ---------------- FSM ----------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:  if (i_valid) w_state_next = StRead;
         StRead:  w_state_next = StWait;
         StWait:  w_state_next = StMix;
         StMix:   w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   assign o_busy   = (r_state != StIdle);
   assign w_accept = (r_state == StIdle) && i_valid;

   // ---------------- Buffer addressing ----------------
   assign w_rd_addr   = r_wr_ptr - r_delay;
   assign w_d_zero    = (r_delay == '0) || (r_delay > r_fill);
   assign w_ram_we    = (r_state == StMix) && !i_rst;
   assign w_ram_addr  = (r_state == StMix) ? r_wr_ptr : w_rd_addr;
   assign w_ram_wdata = {w_y_l, w_y_r};

   always_ff @(posedge i_clk) begin
      if (w_ram_we) begin
         r_mem[w_ram_addr] <= w_ram_wdata;
      end else begin
         r_ram_rdata <= r_mem[w_ram_addr];
      end
   end

   // ---------------- Mix arithmetic ----------------
   assign w_p_l = r_d_l * $signed({1'b0, r_gain});
   assign w_p_r = r_d_r * $signed({1'b0, r_gain});
   assign w_e_l = {w_p_l[ProdW-1], w_p_l[ProdW-1:8]};
   assign w_e_r = {w_p_r[ProdW-1], w_p_r[ProdW-1:8]};
   assign w_s_l = {{2{r_x_l[DATA_W-1]}}, r_x_l} + w_e_l;
   assign w_s_r = {{2{r_x_r[DATA_W-1]}}, r_x_r} + w_e_r;
   assign w_y_l = r_bypass ? r_x_l : sat(w_s_l);
   assign w_y_r = r_bypass ? r_x_r : sat(w_s_r);

   // Fractional product bits are discarded by the Q0.8 scaling.
   assign w_unused = ^{w_p_l[7:0], w_p_r[7:0]};

   // ---------------- Datapath registers ----------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_x_l       <= '0;
         r_x_r       <= '0;
         r_d_l       <= '0;
         r_d_r       <= '0;
         r_delay     <= '0;
         r_gain      <= '0;
         r_bypass    <= 1'b0;
         r_d_zero    <= 1'b1;
         r_wr_ptr    <= '0;
         r_fill      <= '0;
         o_left_out  <= '0;
         o_right_out <= '0;
         o_out_valid <= 1'b0;
         o_overrun   <= 1'b0;
      end else begin
         o_out_valid <= 1'b0;
         if (i_valid && (r_state != StIdle)) begin
            o_overrun <= 1'b1;
         end
         if (w_accept) begin
            r_x_l    <= i_left_in;
            r_x_r    <= i_right_in;
            r_delay  <= i_delay;
            r_gain   <= i_gain;
            r_bypass <= i_bypass;
         end
         if (r_state == StRead) begin
            r_d_zero <= w_d_zero;
         end
         if (r_state == StWait) begin
            r_d_l <= r_d_zero ? '0 : $signed(r_ram_rdata[WordW-1:DATA_W]);
            r_d_r <= r_d_zero ? '0 : $signed(r_ram_rdata[DATA_W-1:0]);
         end
         if (r_state == StMix) begin
            o_left_out  <= w_y_l;
            o_right_out <= w_y_r;
            o_out_valid <= 1'b1;
            r_wr_ptr    <= r_wr_ptr + DEPTH_LOG2'(1);
            if (r_fill != '1) begin
               r_fill <= r_fill + DEPTH_LOG2'(1);
            end
         end
      end
   end

endmodule
